// File: rtl/hilo_div.sv
// hilo_div: multi-cycle 32-bit DIV/DIVU unit writing the HI/LO pair.
// Restoring radix-2 divider on operand magnitudes, then one sign-fix cycle.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           begin a divide (accepted in IDLE or DONE only)
//   is_signed       1 = DIV (two's complement), 0 = DIVU
//   cancel          abort the divide in flight, back to IDLE, no result
//   a, b            dividend, divisor (captured with start)
//   busy            high in CALC and FIX
//   valid           one-cycle strobe in DONE, usable as HI/LO write enable
//   hilo_o          {HI = remainder, LO = quotient}, held between results
//
// Build option: HILO_DIV_ZERO_FAST_EN -- a start with b = 0 skips the
// iterative path and goes straight to DONE on the next edge.

module hilo_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_signed,
    input  logic        cancel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        valid,
    output logic [63:0] hilo_o
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] dvs;
    logic [31:0] rem;
    logic [31:0] quo;
    logic        neg_q;
    logic        neg_r;
    logic        dz;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] r_sh;
    logic [32:0] diff;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    assign a_mag = (is_signed && a[31]) ? (~a + 32'd1) : a;
    assign b_mag = (is_signed && b[31]) ? (~b + 32'd1) : b;

    // Partial remainder shifted left with the next dividend bit; the
    // quotient register doubles as the dividend shift register.
    assign r_sh = {rem, quo[31]};
    assign diff = r_sh - {1'b0, dvs};

    assign q_fix = neg_q ? (~quo + 32'd1) : quo;
    assign r_fix = neg_r ? (~rem + 32'd1) : rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            dvs    <= 32'd0;
            rem    <= 32'd0;
            quo    <= 32'd0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            busy   <= 1'b0;
            valid  <= 1'b0;
            hilo_o <= 64'd0;
        end else if (cancel) begin
            state <= IDLE;
            busy  <= 1'b0;
            valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    valid <= 1'b0;
                    if (start) begin
                        dvs   <= b_mag;
                        rem   <= 32'd0;
                        quo   <= a_mag;
                        cnt   <= 5'd0;
                        neg_q <= is_signed & (a[31] ^ b[31]);
                        neg_r <= is_signed & a[31];
                        dz    <= (b == 32'd0);
`ifdef HILO_DIV_ZERO_FAST_EN
                        if (b == 32'd0) begin
                            state  <= DONE;
                            busy   <= 1'b0;
                            valid  <= 1'b1;
                            hilo_o <= {a, 32'hFFFF_FFFF};
                        end else begin
                            state <= CALC;
                            busy  <= 1'b1;
                        end
`else
                        state <= CALC;
                        busy  <= 1'b1;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    // No borrow means the divisor fits: keep the
                    // difference and shift in a 1 quotient bit.
                    if (!diff[32]) begin
                        rem <= diff[31:0];
                        quo <= {quo[30:0], 1'b1};
                    end else begin
                        rem <= r_sh[31:0];
                        quo <= {quo[30:0], 1'b0};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    valid <= 1'b1;
                    // Divide by zero: the magnitude loop leaves |a| in
                    // rem, so the remainder fix restores a; LO is forced
                    // to all ones regardless of sign.
                    if (dz) begin
                        hilo_o <= {r_fix, 32'hFFFF_FFFF};
                    end else begin
                        hilo_o <= {r_fix, q_fix};
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_div.sv
// tb_hilo_div: directed self-checking bench for hilo_div.
// Cycle k after the start-sampling edge is "T0+k".

module tb_hilo_div;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic        cancel;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        valid;
    logic [63:0] hilo_o;

    int errors;
    int checks;

`ifdef HILO_DIV_ZERO_FAST_EN
    localparam int ZLAT  = 1;
    localparam int ZBUSY = 0;
`else
    localparam int ZLAT  = 34;
    localparam int ZBUSY = 33;
`endif

    hilo_div dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .is_signed(is_signed),
        .cancel   (cancel),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .valid    (valid),
        .hilo_o   (hilo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic sg,
                          input logic [31:0] av,
                          input logic [31:0] bv);
        start     = 1'b1;
        is_signed = sg;
        a         = av;
        b         = bv;
        tick();
        start = 1'b0;
    endtask

    // Watch from T0+1 until valid; optionally pulse start at cycle inj.
    // Leaves the bench in the DONE cycle.
    task automatic wait_done(input string tag,
                             input logic [63:0] exp,
                             input int lat,
                             input int nbusy,
                             input int inj);
        int vc;
        int nb;
        vc = 0;
        nb = 0;
        for (int c = 1; c <= 60; c++) begin
            if (c == inj) begin
                start = 1'b1;
                a     = 32'd1;
                b     = 32'd1;
            end else begin
                start = 1'b0;
            end
            if (valid) begin
                vc = c;
                break;
            end
            if (busy) nb++;
            tick();
        end
        start = 1'b0;
        chk({tag, "_lat"}, 64'(vc), 64'(lat));
        chk({tag, "_busy"}, 64'(nb), 64'(nbusy));
        chk({tag, "_hilo"}, hilo_o, exp);
    endtask

    task automatic op(input string tag,
                      input logic sg,
                      input logic [31:0] av,
                      input logic [31:0] bv,
                      input logic [63:0] exp,
                      input int lat,
                      input int nbusy);
        launch(sg, av, bv);
        wait_done(tag, exp, lat, nbusy, 0);
        tick();
        chk({tag, "_vlow"}, 64'(valid), 64'd0);
        chk({tag, "_hold"}, hilo_o, exp);
    endtask

    initial begin
        int nv;
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        cancel    = 1'b0;
        a         = 32'd0;
        b         = 32'd0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_hilo", hilo_o, 64'd0);

        op("u100_7", 1'b0, 32'd100, 32'd7,
           64'h00000002_0000000E, 34, 33);
        op("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2,
           64'hFFFFFFFF_FFFFFFFD, 34, 33);
        op("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF,
           64'h00000000_80000000, 34, 33);
        op("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE,
           64'h00000001_FFFFFFFD, 34, 33);
        op("u_dz", 1'b0, 32'd5, 32'd0,
           64'h00000005_FFFFFFFF, ZLAT, ZBUSY);
        op("s_dz", 1'b1, 32'hFFFFFFF9, 32'd0,
           64'hFFFFFFF9_FFFFFFFF, ZLAT, ZBUSY);

        // Cancel in cycle T0+10: idle from T0+11, no result.
        launch(1'b0, 32'd1000, 32'd3);
        for (int c = 1; c < 10; c++) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cxl_busy", 64'(busy), 64'd0);
        nv = 0;
        for (int c = 0; c < 40; c++) begin
            if (valid) nv++;
            tick();
        end
        chk("cxl_novalid", 64'(nv), 64'd0);
        chk("cxl_hilo", hilo_o, 64'hFFFFFFF9_FFFFFFFF);

        // Cancel beats a same-cycle start.
        start  = 1'b1;
        cancel = 1'b1;
        a      = 32'd9;
        b      = 32'd3;
        tick();
        start  = 1'b0;
        cancel = 1'b0;
        chk("cxs_busy", 64'(busy), 64'd0);
        nv = 0;
        for (int c = 0; c < 40; c++) begin
            if (valid) nv++;
            tick();
        end
        chk("cxs_novalid", 64'(nv), 64'd0);

        // New divide after cancel, then back-to-back start in DONE.
        launch(1'b0, 32'd9, 32'd3);
        wait_done("u9_3", 64'h00000000_00000003, 34, 33, 0);
        launch(1'b0, 32'hFFFFFFFF, 32'h10);
        chk("b2b_busy", 64'(busy), 64'd1);
        // The loop re-samples cycle 1, so it counts from T0+1 again.
        wait_done("b2b", 64'h0000000F_0FFFFFFF, 34, 33, 5);
        tick();
        chk("b2b_vlow", 64'(valid), 64'd0);

        // Reset at T0+20 discards the divide.
        launch(1'b0, 32'd100, 32'd7);
        for (int c = 1; c < 20; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_valid", 64'(valid), 64'd0);
        chk("mrst_hilo", hilo_o, 64'd0);
        nv = 0;
        for (int c = 0; c < 40; c++) begin
            if (valid) nv++;
            tick();
        end
        chk("mrst_novalid", 64'(nv), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
